fetch_stage: RTL and testbench

//  Instruction-fetch front end: owns the PC, issues in-order word reads to instruction

---
 rtl/fetch_pkg.sv | 25 ++
 rtl/fetch_stage_chk.sv | 38 +++
 rtl/sync_fifo.sv | 72 +++++++
 rtl/fetch_stage.sv | 131 +++++++++++++
 tb/tb_fetch_stage.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// Entry layouts for the pending-request FIFO and the delivered-instruction FIFO.
package fetch_pkg;

  localparam int                      FETCH_DWIDTH   = 32;
  localparam int                      FETCH_AWIDTH   = 32;
  localparam logic [FETCH_AWIDTH-1:0] FETCH_BASEADDR = 32'h0100_0000;
  localparam int                      INSN_BYTES     = 4;

  typedef struct packed {
    logic [FETCH_AWIDTH-1:0] pc;
    logic [FETCH_DWIDTH-1:0] insn;
  } fetch_entry_t;

  typedef struct packed {
    logic [FETCH_AWIDTH-1:0] pc;
    logic                    epoch;
  } pend_entry_t;

  // Instruction fetches are word granular; the low address bits are dropped.
  function automatic logic [FETCH_AWIDTH-1:0] word_align(input logic [FETCH_AWIDTH-1:0] addr);
    return {addr[FETCH_AWIDTH-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_chk.sv
// Protocol checks for fetch_stage: response ordering, FIFO overflow and output hold.
// Simulation-only properties; carries no functional logic.
module fetch_stage_chk #(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32
) (
  input logic              clk,
  input logic              rst,
  input logic              rsp_valid,
  input logic              pend_empty,
  input logic              pend_full,
  input logic              pend_push,
  input logic              pend_pop,
  input logic              out_full,
  input logic              out_push,
  input logic              out_pop,
  input logic              redirect,
  input logic              out_valid,
  input logic              out_ready,
  input logic [AWIDTH-1:0] out_pc,
  input logic [DWIDTH-1:0] out_insn
);

  // A response must always have an outstanding request to pair with
  a_rsp_has_pending: assert property (@(posedge clk) disable iff (rst)
    rsp_valid |-> !pend_empty);

  a_pend_no_overflow: assert property (@(posedge clk) disable iff (rst)
    pend_push |-> (!pend_full || pend_pop));

  a_out_no_overflow: assert property (@(posedge clk) disable iff (rst)
    out_push |-> (!out_full || out_pop));

  a_out_hold: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready && !redirect) |=>
      (out_valid && $stable(out_pc) && $stable(out_insn)));

endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with clear, occupancy count and full/empty flags.
// Push while full is accepted only when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter type T     = logic [7:0],
  parameter int  DEPTH = 2,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          push,
  input  T              push_data,
  input  logic          pop,
  output T              head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam logic [AW-1:0] PTR_INC = AW'(1'b1);
  localparam logic [CW-1:0] CNT_INC = CW'(1'b1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  T              mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          do_push_s;
  logic          do_pop_s;

  // Qualify requests against the current occupancy
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Storage, pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clear) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= push_data;
        wr_ptr_r        <= wr_ptr_r + PTR_INC;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_INC;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + CNT_INC;
        2'b01:   count_r <= count_r - CNT_INC;
        default: count_r <= count_r;
      endcase
    end
  end

  assign head  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == CNT_MAX);
  assign empty = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: owns the PC, issues in-order word reads and delivers
// {pc, insn} downstream; redirects flush buffered output and squash in-flight reads by epoch.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int                DWIDTH   = FETCH_DWIDTH,
  parameter int                AWIDTH   = FETCH_AWIDTH,
  parameter logic [AWIDTH-1:0] BASEADDR = FETCH_BASEADDR,
  parameter int                DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [AWIDTH-1:0] out_pc_o,
  output logic [DWIDTH-1:0] out_insn_o
);

  localparam int                CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]       DEPTH_W = (CW+1)'(DEPTH);
  localparam logic [AWIDTH-1:0] PC_STEP = AWIDTH'(INSN_BYTES);

  logic [AWIDTH-1:0] pc_r;
  logic              epoch_r;
  logic              accept_s;
  logic              rsp_take_s;
  logic              rsp_keep_s;
  logic              out_pop_s;
  logic              credit_ok_s;
  logic [CW:0]       in_use_s;
  logic [CW-1:0]     pend_cnt_s;
  logic [CW-1:0]     out_cnt_s;
  logic              pend_full_s;
  logic              pend_empty_s;
  logic              out_full_s;
  logic              out_empty_s;
  pend_entry_t       pend_push_s;
  pend_entry_t       pend_head_s;
  fetch_entry_t      out_push_s;
  fetch_entry_t      out_head_s;

  // Credit check covers in-flight plus buffered, so every response has an output slot
  always_comb begin
    in_use_s         = {1'b0, pend_cnt_s} + {1'b0, out_cnt_s};
    credit_ok_s      = (in_use_s < DEPTH_W);
    imem_req_valid_o = !rst && !redirect_i && credit_ok_s;
    accept_s         = imem_req_valid_o && imem_req_ready_i;
    rsp_take_s       = imem_rsp_valid_i && !pend_empty_s;
    rsp_keep_s       = rsp_take_s && !redirect_i && (pend_head_s.epoch == epoch_r);
    out_pop_s        = !out_empty_s && out_ready_i && !redirect_i;
    pend_push_s.pc    = pc_r;
    pend_push_s.epoch = epoch_r;
    out_push_s.pc     = pend_head_s.pc;
    out_push_s.insn   = imem_rsp_data_i;
  end

  // PC and epoch; a redirect outranks any issue in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r    <= BASEADDR;
      epoch_r <= 1'b0;
    end else if (redirect_i) begin
      pc_r    <= word_align(redirect_pc_i);
      epoch_r <= ~epoch_r;
    end else if (accept_s) begin
      pc_r    <= pc_r + PC_STEP;
      epoch_r <= epoch_r;
    end else begin
      pc_r    <= pc_r;
      epoch_r <= epoch_r;
    end
  end

  // Stale entries stay queued so they pair up with their responses and get dropped
  sync_fifo #(.T(pend_entry_t), .DEPTH(DEPTH)) u_pend_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (1'b0),
    .push      (accept_s),
    .push_data (pend_push_s),
    .pop       (rsp_take_s),
    .head      (pend_head_s),
    .count     (pend_cnt_s),
    .full      (pend_full_s),
    .empty     (pend_empty_s)
  );

  sync_fifo #(.T(fetch_entry_t), .DEPTH(DEPTH)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_i),
    .push      (rsp_keep_s),
    .push_data (out_push_s),
    .pop       (out_pop_s),
    .head      (out_head_s),
    .count     (out_cnt_s),
    .full      (out_full_s),
    .empty     (out_empty_s)
  );

  assign imem_addr_o = pc_r;
  assign out_valid_o = !out_empty_s;
  assign out_pc_o    = out_head_s.pc;
  assign out_insn_o  = out_head_s.insn;

  fetch_stage_chk #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) u_chk (
    .clk        (clk),
    .rst        (rst),
    .rsp_valid  (imem_rsp_valid_i),
    .pend_empty (pend_empty_s),
    .pend_full  (pend_full_s),
    .pend_push  (accept_s),
    .pend_pop   (rsp_take_s),
    .out_full   (out_full_s),
    .out_push   (rsp_keep_s),
    .out_pop    (out_pop_s),
    .redirect   (redirect_i),
    .out_valid  (out_valid_o),
    .out_ready  (out_ready_i),
    .out_pc     (out_pc_o),
    .out_insn   (out_insn_o)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a queue-based reference model and an
// in-order variable-latency instruction memory model.
module tb_fetch_stage;

  localparam int          DEPTH = 2;
  localparam logic [31:0] BASE  = 32'h0100_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [31:0] out_pc_o;
  logic [31:0] out_insn_o;

  always #5 clk = ~clk;

  fetch_stage #(.DWIDTH(32), .AWIDTH(32), .BASEADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_addr_o      (imem_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .redirect_i       (redirect_i),
    .redirect_pc_i    (redirect_pc_i),
    .out_valid_o      (out_valid_o),
    .out_ready_i      (out_ready_i),
    .out_pc_o         (out_pc_o),
    .out_insn_o       (out_insn_o)
  );

  typedef struct { logic [31:0] pc; int gen; } pend_t;
  typedef struct { logic [31:0] pc; logic [31:0] insn; } outw_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  pend_t       pend_q[$];
  outw_t       out_q[$];
  mreq_t       mem_q[$];
  logic [31:0] m_pc;
  int          m_gen;
  int          cyc;
  int          n_checks;
  int          n_fail;
  int          p_ready;
  int          p_oready;
  int          p_redir;
  int          lat_max;
  logic        force_redir;
  logic [31:0] force_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // One clock: drive at negedge, check shortly after, update models at posedge.
  task automatic step();
    logic  rsp_now;
    logic  exp_req;
    logic  acc;
    logic  redir_ok;
    logic  do_pop;
    int    due;
    pend_t h;
    outw_t o;
    redir_ok = 1'b1;
    foreach (pend_q[i]) if (pend_q[i].gen != m_gen) redir_ok = 1'b0;
    @(negedge clk);
    imem_req_ready_i = ($urandom_range(99) < p_ready);
    out_ready_i      = ($urandom_range(99) < p_oready);
    if (force_redir && redir_ok) begin
      redirect_i    = 1'b1;
      redirect_pc_i = force_pc;
      force_redir   = 1'b0;
    end else if (!force_redir && redir_ok && ($urandom_range(99) < p_redir)) begin
      redirect_i    = 1'b1;
      redirect_pc_i = $urandom();
    end else begin
      redirect_i    = 1'b0;
      redirect_pc_i = $urandom();
    end
    rsp_now          = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    imem_rsp_valid_i = rsp_now;
    imem_rsp_data_i  = rsp_now ? mem_word(mem_q[0].addr) : $urandom();
    #1;
    exp_req = !redirect_i && ((pend_q.size() + out_q.size()) < DEPTH);
    check("req_valid", 64'(imem_req_valid_o), 64'(exp_req));
    if (exp_req) check("req_addr", 64'(imem_addr_o), 64'(m_pc));
    check("out_valid", 64'(out_valid_o), 64'(out_q.size() > 0));
    if (out_q.size() > 0) begin
      check("out_pc", 64'(out_pc_o), 64'(out_q[0].pc));
      check("out_insn", 64'(out_insn_o), 64'(out_q[0].insn));
    end
    acc = exp_req && imem_req_ready_i;
    @(posedge clk);
    if (rsp_now) void'(mem_q.pop_front());
    if (acc) begin
      due = cyc + int'($urandom_range(lat_max, 1));
      if (mem_q.size() > 0 && due <= mem_q[mem_q.size()-1].due) due = mem_q[mem_q.size()-1].due + 1;
      mem_q.push_back('{addr: m_pc, due: due});
    end
    do_pop = !redirect_i && (out_q.size() > 0) && out_ready_i;
    if (do_pop) void'(out_q.pop_front());
    if (rsp_now && pend_q.size() > 0) begin
      h = pend_q.pop_front();
      if (!redirect_i && h.gen == m_gen) begin
        o.pc   = h.pc;
        o.insn = mem_word(h.pc);
        out_q.push_back(o);
      end
    end
    if (redirect_i) begin
      out_q.delete();
      m_gen++;
      m_pc = redirect_pc_i & 32'hFFFF_FFFC;
    end else if (acc) begin
      h.pc  = m_pc;
      h.gen = m_gen;
      pend_q.push_back(h);
      m_pc = m_pc + 32'd4;
    end
    cyc++;
  endtask

  // Reset with memory stalled and downstream stalled; outputs must return to reset values.
  task automatic do_reset();
    @(negedge clk);
    rst              = 1'b1;
    imem_req_ready_i = 1'b0;
    out_ready_i      = 1'b0;
    imem_rsp_valid_i = 1'b0;
    redirect_i       = 1'b0;
    #1;
    check("rst_req_valid", 64'(imem_req_valid_o), 64'd0);
    @(posedge clk);
    pend_q.delete();
    out_q.delete();
    mem_q.delete();
    m_pc  = BASE;
    m_gen = 0;
    cyc++;
    @(negedge clk);
    #1;
    check("rst_req_valid_q", 64'(imem_req_valid_o), 64'd0);
    check("rst_addr", 64'(imem_addr_o), 64'(BASE));
    check("rst_out_valid", 64'(out_valid_o), 64'd0);
    check("rst_out_pc", 64'(out_pc_o), 64'd0);
    check("rst_out_insn", 64'(out_insn_o), 64'd0);
    rst = 1'b0;
    #1;
    check("rst_release_req", 64'(imem_req_valid_o), 64'd1);
  endtask

  initial begin
    rst              = 1'b1;
    imem_req_ready_i = 1'b0;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = 32'd0;
    redirect_i       = 1'b0;
    redirect_pc_i    = 32'd0;
    out_ready_i      = 1'b0;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    m_pc     = BASE;
    m_gen    = 0;
    force_redir = 1'b0;
    force_pc    = 32'd0;
    p_ready  = 100;
    p_oready = 100;
    p_redir  = 0;
    lat_max  = 1;

    do_reset();
    repeat (20) step();

    p_oready = 0;
    repeat (10) step();
    p_oready = 100;
    repeat (10) step();

    lat_max = 3;
    repeat (4) step();
    force_pc    = 32'h0100_0203;
    force_redir = 1'b1;
    repeat (15) step();

    force_pc    = 32'hFFFF_FFFC;
    force_redir = 1'b1;
    repeat (12) step();

    p_ready  = 70;
    p_oready = 70;
    lat_max  = 2;
    repeat (40) step();
    p_ready  = 100;
    p_oready = 0;
    repeat (6) step();
    do_reset();

    for (int k = 0; k < 6; k++) begin
      p_ready  = int'($urandom_range(100, 20));
      p_oready = int'($urandom_range(100, 20));
      p_redir  = int'($urandom_range(15, 2));
      lat_max  = int'($urandom_range(4, 1));
      repeat (300) step();
      do_reset();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
